axi4lite_regif: RTL and testbench
=================================

# axi4lite_regif

AXI4-Lite slave front end for the GPIO register block, parametrised in address width, data width and register window. It accepts write address, write data and read address independently, each into a one-entry holding buffer. A single sequencer arbitrates round-robin between reads and writes, drives the register block strobes, and returns OKAY, SLVERR or DECERR responses. It replaces the fixed 32-bit interface and adds byte strobes, out-of-window decode and read/write fairness.

## Interface
Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 32: data width; legal values are 32 and 64. ADDR_LSB = log2(DATA_W/8).
- REG_AW, 8: register word-address width; the window covers 2^REG_AW words.

Ports:
- iCLK  in  1  clock; all logic is on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iAWADDR  in  ADDR_W  write address.
- iAWVALID / oAWREADY  in / out  1  write-address handshake.
- iWDATA  in  DATA_W  write data.
- iWSTRB  in  DATA_W/8  write byte strobes.
- iWVALID / oWREADY  in / out  1  write-data handshake.
- oBRESP  out  2  write response.
- oBVALID / iBREADY  out / in  1  write-response handshake.
- iARADDR  in  ADDR_W  read address.
- iARVALID / oARREADY  in / out  1  read-address handshake.
- oRDATA  out  DATA_W  read data.
- oRRESP  out  2  read response.
- oRVALID / iRREADY  out / in  1  read-data handshake.
- oPWADR  out  REG_AW  register write word address.
- oPWDAT  out  DATA_W  register write data.
- oPWSTB  out  DATA_W/8  register write byte enables.
- oPWRTE  out  1  one-cycle register write strobe.
- oPRADR  out  REG_AW  register read word address.
- oPRDEN  out  1  one-cycle register read strobe.
- iPRDAT  in  DATA_W  register read data.
- iPERR  in  1  register error, valid in the cycle iPRDAT is sampled or in the cycle oPWRTE is high.

## Operation
- Holding buffers: AW, W and AR each have a full flag.
  - oAWREADY = ~awFull & ~iRST. oWREADY and oARREADY follow the same rule with their own flags.
  - A flag sets on its handshake.
  - AW and W flags clear together on the B handshake. The AR flag clears on the R handshake.
- Decode: word address = ADDR[ADDR_LSB+REG_AW-1:ADDR_LSB].
  - Bits below ADDR_LSB are ignored.
  - If any bit ADDR[ADDR_W-1:ADDR_LSB+REG_AW] is nonzero, the access is out of window.
- Sequencer states: IDLE, WR, WRESP, RD, RDWAIT (macro builds only), RRESP.
  - In IDLE, a write is eligible when awFull & wFull. A read is eligible when arFull.
  - Both eligible: the grant goes opposite to lastGrant. lastGrant resets to "read", so the first contested grant goes to the write.
  - WR, one cycle: oPWRTE=1, with oPWADR/oPWDAT/oPWSTB taken from the buffers. Response latches SLVERR (2'b10) if iPERR, else OKAY. Next state WRESP.
  - WR, out of window: oPWRTE stays 0 and the response is DECERR (2'b11). Next state WRESP.
  - WRESP: oBVALID=1 until iBREADY, then IDLE.
  - RD, one cycle: oPRDEN=1 and oPRADR driven. iPRDAT/iPERR are captured into oRDATA/oRRESP. Next state RRESP.
  - RD, out of window: oPRDEN stays 0, oRDATA=0, oRRESP=DECERR.
  - RRESP: oRVALID=1 until iRREADY, then IDLE.
- Outputs are stable while VALID is high and not yet accepted.
- Reset values: all outputs are 0 (ready outputs are forced low by iRST), all flags are clear, and the state is IDLE.
- Reset asserted mid-transaction discards the transaction. No strobe or response is issued for it.

## Timing
- Let T be the cycle of the later of the AW/W handshakes. oPWRTE is high at T+1 and oBVALID at T+2, provided the sequencer is IDLE.
- AR handshake at T: oPRDEN at T+1, oRVALID at T+2 (T+3 with the macro).
- oAWREADY/oWREADY return high the cycle after the B handshake. oARREADY returns high the cycle after the R handshake.
- AW and W may arrive in either order or in the same cycle. An AR may be buffered while a write is in flight.
- Minimum spacing is 3 cycles per write and 3 cycles per read. With continuous contention, grants alternate.

## Configuration
- AXIL_RD_PIPE_EN defined:
  - RD strobes oPRDEN and moves to RDWAIT.
  - iPRDAT/iPERR are sampled in RDWAIT, one cycle after oPRDEN, for registered register-block outputs.
  - Read latency is +1 cycle.
- AXIL_RD_PIPE_EN undefined: no RDWAIT state; iPRDAT/iPERR are sampled in the oPRDEN cycle.
- Write path and DECERR reads are identical in both builds.

## Test plan
- Reset: hold iRST 3 cycles with random inputs -> all outputs 0. After release, oAWREADY/oWREADY/oARREADY=1.
- Write ordering: W (0xDEADBEEF, strb 0xF) 2 cycles before AW 0x0000_0010 (DATA_W=32) -> oPWRTE one cycle with oPWADR=0x04, oPWSTB=0xF. Then oBVALID=1, oBRESP=0; hold iBREADY=0 for 4 cycles -> oBVALID stays high.
- Read errors: read 0x0000_0008 with iPERR=1 -> oRRESP=2'b10, oRDATA=iPRDAT. Read 0x0000_0400 (REG_AW=8) -> oPRDEN never pulses, oRRESP=2'b11, oRDATA=0.
- Contention: AW+W and AR presented in the same cycle after reset -> write served first. Repeat 4 times -> grants alternate W,R,W,R.
- Mid-transaction reset: iRST pulsed during WRESP -> oBVALID drops immediately. No oPWRTE is reissued after release.
- Read pipelining: with AXIL_RD_PIPE_EN, AR at T -> oPRDEN at T+1 and oRVALID at T+3, with oRDATA equal to iPRDAT at T+2.

Source files
------------

// File: rtl/axi4lite_regif.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : axi4lite_regif                                               |
// | Purpose  : AXI4-Lite slave front end for the GPIO register block.       |
// |            One-entry AW/W/AR holding buffers, round-robin read/write    |
// |            sequencer, register strobes, OKAY/SLVERR/DECERR responses.   |
// | Options  : AXIL_RD_PIPE_EN - sample iPRDAT/iPERR one cycle after oPRDEN |
// |            for register blocks with registered read outputs.            |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module axi4lite_regif #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 8
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [ADDR_W-1:0]   iAWADDR,
  input  logic                iAWVALID,
  output logic                oAWREADY,
  input  logic [DATA_W-1:0]   iWDATA,
  input  logic [DATA_W/8-1:0] iWSTRB,
  input  logic                iWVALID,
  output logic                oWREADY,
  output logic [1:0]          oBRESP,
  output logic                oBVALID,
  input  logic                iBREADY,
  input  logic [ADDR_W-1:0]   iARADDR,
  input  logic                iARVALID,
  output logic                oARREADY,
  output logic [DATA_W-1:0]   oRDATA,
  output logic [1:0]          oRRESP,
  output logic                oRVALID,
  input  logic                iRREADY,
  output logic [REG_AW-1:0]   oPWADR,
  output logic [DATA_W-1:0]   oPWDAT,
  output logic [DATA_W/8-1:0] oPWSTB,
  output logic                oPWRTE,
  output logic [REG_AW-1:0]   oPRADR,
  output logic                oPRDEN,
  input  logic [DATA_W-1:0]   iPRDAT,
  input  logic                iPERR
);

  localparam int ADDR_LSB = (DATA_W == 64) ? 3 : 2;
  localparam int WIN_TOP  = ADDR_LSB + REG_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WRESP  = 3'd2,
    ST_RD     = 3'd3,
`ifdef AXIL_RD_PIPE_EN
    ST_RDWAIT = 3'd4,
`endif
    ST_RRESP  = 3'd5
  } state_t;

  state_t state;

  logic                aw_full, w_full, ar_full;
  logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic last_rd;     // 1: last grant went to a read
  logic wr_dec;      // current write is out of window
  logic rd_dec;      // current read is out of window

  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic [REG_AW-1:0]   wr_word, rd_word;
  logic                wr_oob, rd_oob;
  logic [1:0]          rd_resp;

  // Ready outputs: a buffer accepts while empty, never during reset.
  assign oAWREADY = ~aw_full & ~iRST;
  assign oWREADY  = ~w_full  & ~iRST;
  assign oARREADY = ~ar_full & ~iRST;

  assign aw_hs = iAWVALID & oAWREADY;
  assign w_hs  = iWVALID  & oWREADY;
  assign ar_hs = iARVALID & oARREADY;
  assign b_hs  = oBVALID  & iBREADY;
  assign r_hs  = oRVALID  & iRREADY;

  // A request arriving this cycle is visible to the sequencer without waiting
  // for its buffer flag, which keeps strobe latency at one cycle.
  assign wr_addr = aw_full ? aw_addr_q : iAWADDR;
  assign wr_data = w_full  ? w_data_q  : iWDATA;
  assign wr_strb = w_full  ? w_strb_q  : iWSTRB;
  assign rd_addr = ar_full ? ar_addr_q : iARADDR;

  assign wr_word = wr_addr[ADDR_LSB +: REG_AW];
  assign rd_word = rd_addr[ADDR_LSB +: REG_AW];
  assign wr_oob  = (wr_addr >> WIN_TOP) != '0;
  assign rd_oob  = (rd_addr >> WIN_TOP) != '0;

  assign wr_elig  = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_elig  = ar_full | ar_hs;
  assign grant_wr = wr_elig & (~rd_elig | last_rd);
  assign grant_rd = rd_elig & ~grant_wr;

  assign rd_resp = iPERR ? RESP_SLVERR : RESP_OKAY;

  // Holding buffers: fill on handshake, drain when the response is accepted.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= iAWADDR;
      end else if (b_hs) begin
        aw_full   <= 1'b0;
      end
      if (w_hs) begin
        w_full    <= 1'b1;
        w_data_q  <= iWDATA;
        w_strb_q  <= iWSTRB;
      end else if (b_hs) begin
        w_full    <= 1'b0;
      end
      if (ar_hs) begin
        ar_full   <= 1'b1;
        ar_addr_q <= iARADDR;
      end else if (r_hs) begin
        ar_full   <= 1'b0;
      end
    end
  end

  // Sequencer: arbitration, register strobes and registered AXI responses.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= ST_IDLE;
      last_rd <= 1'b1;
      wr_dec  <= 1'b0;
      rd_dec  <= 1'b0;
      oPWADR  <= '0;
      oPWDAT  <= '0;
      oPWSTB  <= '0;
      oPWRTE  <= 1'b0;
      oPRADR  <= '0;
      oPRDEN  <= 1'b0;
      oBVALID <= 1'b0;
      oBRESP  <= RESP_OKAY;
      oRVALID <= 1'b0;
      oRRESP  <= RESP_OKAY;
      oRDATA  <= '0;
    end else begin
      oPWRTE <= 1'b0;
      oPRDEN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            last_rd <= 1'b0;
            wr_dec  <= wr_oob;
            oPWADR  <= wr_word;
            oPWDAT  <= wr_data;
            oPWSTB  <= wr_strb;
            oPWRTE  <= ~wr_oob;
            state   <= ST_WR;
          end else if (grant_rd) begin
            last_rd <= 1'b1;
            rd_dec  <= rd_oob;
            oPRADR  <= rd_word;
            oPRDEN  <= ~rd_oob;
            state   <= ST_RD;
          end
        end
        ST_WR: begin
          oBVALID <= 1'b1;
          oBRESP  <= wr_dec ? RESP_DECERR : (iPERR ? RESP_SLVERR : RESP_OKAY);
          state   <= ST_WRESP;
        end
        ST_WRESP: begin
          if (iBREADY) begin
            oBVALID <= 1'b0;
            state   <= ST_IDLE;
          end
        end
`ifdef AXIL_RD_PIPE_EN
        ST_RD: begin
          if (rd_dec) begin
            oRVALID <= 1'b1;
            oRDATA  <= '0;
            oRRESP  <= RESP_DECERR;
            state   <= ST_RRESP;
          end else begin
            state   <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          oRVALID <= 1'b1;
          oRDATA  <= iPRDAT;
          oRRESP  <= rd_resp;
          state   <= ST_RRESP;
        end
`else
        ST_RD: begin
          oRVALID <= 1'b1;
          oRDATA  <= rd_dec ? '0 : iPRDAT;
          oRRESP  <= rd_dec ? RESP_DECERR : rd_resp;
          state   <= ST_RRESP;
        end
`endif
        ST_RRESP: begin
          if (iRREADY) begin
            oRVALID <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_regif.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_axi4lite_regif                                            |
// | Purpose  : Self-checking bench for axi4lite_regif with a register-block |
// |            stand-in and a transaction-level reference model.            |
// | Options  : AXIL_RD_PIPE_EN - expects the extra read-pipeline cycle.     |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_axi4lite_regif;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_AW = 8;
`ifdef AXIL_RD_PIPE_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 2;
`endif
  localparam byte GW = 8'h57;  // 'W'
  localparam byte GR = 8'h52;  // 'R'

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid, pwrte, prden, perr;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, pwdat, prdat;
  logic [3:0]  pwstb;
  logic [7:0]  pwadr, pradr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4lite_regif #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .iCLK(clk), .iRST(rst),
    .iAWADDR(awaddr), .iAWVALID(awvalid), .oAWREADY(awready),
    .iWDATA(wdata), .iWSTRB(wstrb), .iWVALID(wvalid), .oWREADY(wready),
    .oBRESP(bresp), .oBVALID(bvalid), .iBREADY(bready),
    .iARADDR(araddr), .iARVALID(arvalid), .oARREADY(arready),
    .oRDATA(rdata), .oRRESP(rresp), .oRVALID(rvalid), .iRREADY(rready),
    .oPWADR(pwadr), .oPWDAT(pwdat), .oPWSTB(pwstb), .oPWRTE(pwrte),
    .oPRADR(pradr), .oPRDEN(prden), .iPRDAT(prdat), .iPERR(perr)
  );

  // Register-block stand-in: word 2 and words 0xF0-0xFF report errors and
  // return a fixed tag instead of storage; every other word is plain storage.
  function automatic logic is_err(input logic [7:0] w);
    return (w == 8'd2) || (w[7:4] == 4'hF);
  endfunction
  function automatic logic [31:0] err_tag(input logic [7:0] w);
    return 32'hE770_0000 | {24'h0, w};
  endfunction

  logic [31:0] regs [256] = '{default: 32'h0};
  logic        rd_err;

  always @(posedge clk)
    if (pwrte && !is_err(pwadr))
      for (int b = 0; b < 4; b++)
        if (pwstb[b]) regs[pwadr][8*b +: 8] <= pwdat[8*b +: 8];

`ifdef AXIL_RD_PIPE_EN
  logic       rd_q = 1'b0;
  logic [7:0] adr_q = '0;
  always @(posedge clk) begin
    rd_q  <= prden;
    adr_q <= pradr;
  end
  assign prdat  = is_err(adr_q) ? err_tag(adr_q) : regs[adr_q];
  assign rd_err = rd_q & is_err(adr_q);
`else
  assign prdat  = is_err(pradr) ? err_tag(pradr) : regs[pradr];
  assign rd_err = prden & is_err(pradr);
`endif
  assign perr = (pwrte & is_err(pwadr)) | rd_err;

  // Strobe monitor
  int         cyc = 0;
  int         pw_cnt = 0, pr_cnt = 0, pw_cyc = 0, pr_cyc = 0;
  logic [7:0] pw_adr_s = '0, pr_adr_s = '0;
  logic [31:0] pw_dat_s = '0;
  logic [3:0] pw_stb_s = '0;
  byte        grant_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pwrte) begin
      pw_cnt++; pw_cyc = cyc; pw_adr_s = pwadr; pw_dat_s = pwdat; pw_stb_s = pwstb;
      grant_q.push_back(GW);
    end
    if (prden) begin
      pr_cnt++; pr_cyc = cyc; pr_adr_s = pradr;
      grant_q.push_back(GR);
    end
  end

  // Reference model: register contents and arbitration history.
  logic [31:0] model_mem [256] = '{default: 32'h0};
  bit          last_was_read = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic oob_of(input logic [31:0] a);
    return a[31:10] != 22'h0;
  endfunction

  task automatic model_write(input logic [7:0] w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_stall);
    int t_aw = -1, t_w = -1, t, n, pw0;
    logic [7:0] wd;
    logic [1:0] eresp;
    bit oob, err;
    wd = addr[9:2]; oob = oob_of(addr); err = is_err(wd); pw0 = pw_cnt;
    n = 0;
    while ((t_aw < 0 || t_w < 0) && n < 40) begin
      awvalid = (t_aw < 0) && (n >= aw_dly); awaddr = addr;
      wvalid  = (t_w < 0) && (n >= w_dly);  wdata = data; wstrb = strb;
      if (awvalid && awready) t_aw = cyc;
      if (wvalid && wready) t_w = cyc;
      tick(); n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", (t_aw >= 0) && (t_w >= 0), 1);
    t = (t_aw > t_w) ? t_aw : t_w;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid_seen", bvalid, 1);
    check("wr_b_latency", cyc - t, 2);
    if (oob) eresp = 2'b11;
    else if (err) eresp = 2'b10;
    else begin eresp = 2'b00; model_write(wd, data, strb); end
    check("wr_bresp", bresp, eresp);
    check("wr_strobe_count", pw_cnt - pw0, oob ? 1'b0 : 1'b1);
    if (!oob) begin
      check("wr_pwadr", pw_adr_s, wd);
      check("wr_pwdat", pw_dat_s, data);
      check("wr_pwstb", pw_stb_s, strb);
      check("wr_strobe_latency", pw_cyc - t, 1);
    end
    for (int i = 0; i < b_stall; i++) begin
      tick();
      check("wr_bvalid_hold", {bvalid, bresp}, {1'b1, eresp});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wr_bvalid_drop", bvalid, 0);
    check("wr_ready_return", {awready, wready}, 2'b11);
    last_was_read = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_stall);
    int t = -1, n, pr0;
    logic [7:0]  wd;
    logic [31:0] edata;
    logic [1:0]  eresp;
    bit oob;
    wd = addr[9:2]; oob = oob_of(addr); pr0 = pr_cnt;
    n = 0;
    while (t < 0 && n < 40) begin
      arvalid = (n >= ar_dly); araddr = addr;
      if (arvalid && arready) t = cyc;
      tick(); n++;
    end
    arvalid = 1'b0;
    check("rd_accept", t >= 0, 1);
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    check("rd_rvalid_seen", rvalid, 1);
    check("rd_latency", cyc - t, oob ? 2 : RD_LAT);
    if (oob) begin edata = 32'h0; eresp = 2'b11; end
    else if (is_err(wd)) begin edata = err_tag(wd); eresp = 2'b10; end
    else begin edata = model_mem[wd]; eresp = 2'b00; end
    check("rd_rdata", rdata, edata);
    check("rd_rresp", rresp, eresp);
    check("rd_strobe_count", pr_cnt - pr0, oob ? 1'b0 : 1'b1);
    if (!oob) begin
      check("rd_pradr", pr_adr_s, wd);
      check("rd_strobe_latency", pr_cyc - t, 1);
    end
    for (int i = 0; i < r_stall; i++) begin
      tick();
      check("rd_rvalid_hold", {rvalid, rresp, rdata}, {1'b1, eresp, edata});
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rd_rvalid_drop", rvalid, 0);
    check("rd_ready_return", arready, 1);
    last_was_read = 1'b1;
  endtask

  // AW+W and AR presented together; the model predicts grant order and data.
  task automatic contend(input logic [7:0] ww, input logic [31:0] data, input logic [7:0] rw);
    byte first, second;
    bit got_b = 1'b0, got_r = 1'b0;
    logic [1:0]  b_obs = '0, r_obs = '0;
    logic [31:0] d_obs = '0, edata;
    int n = 0;
    first  = last_was_read ? GW : GR;
    second = (first == GW) ? GR : GW;
    grant_q.delete();
    awaddr = {22'h0, ww, 2'b00}; wdata = data; wstrb = 4'hF;
    araddr = {22'h0, rw, 2'b00};
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b1; rready = 1'b1;
    check("ct_all_ready", {awready, wready, arready}, 3'b111);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    while ((!got_b || !got_r) && n < 30) begin
      if (bvalid) begin got_b = 1'b1; b_obs = bresp; end
      if (rvalid) begin got_r = 1'b1; r_obs = rresp; d_obs = rdata; end
      tick(); n++;
    end
    bready = 1'b0; rready = 1'b0;
    check("ct_both_done", {got_b, got_r}, 2'b11);
    if (first == GW) begin
      model_write(ww, data, 4'hF); edata = model_mem[rw];
    end else begin
      edata = model_mem[rw]; model_write(ww, data, 4'hF);
    end
    check("ct_grant_count", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      check("ct_grant_first", grant_q[0], first);
      check("ct_grant_second", grant_q[1], second);
    end
    check("ct_bresp", b_obs, 2'b00);
    check("ct_rresp", r_obs, 2'b00);
    check("ct_rdata", d_obs, edata);
    last_was_read = (second == GR);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int pw0, n;
    logic [31:0] a;
    logic [7:0]  w;

    // Reset held three cycles with random inputs on every port
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      awaddr = $urandom; wdata = $urandom; araddr = $urandom; wstrb = 4'($urandom);
      awvalid = 1'($urandom); wvalid = 1'($urandom); arvalid = 1'($urandom);
      bready = 1'($urandom); rready = 1'($urandom);
      tick();
      check("rst_ctrl", {awready, wready, arready, bvalid, rvalid, pwrte, prden, bresp, rresp}, 0);
      check("rst_data", {pwadr, pradr, pwstb, rdata}, 0);
      check("rst_pwdat", pwdat, 0);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    rst = 1'b0;
    last_was_read = 1'b1;
    tick();
    check("rst_release_ready", {awready, wready, arready}, 3'b111);

    // Contention straight after reset, four rounds
    for (int i = 0; i < 4; i++)
      contend(8'(16 + i), $urandom, 8'(16 + ((i + 1) % 4)));

    // W two cycles ahead of AW, response held off four cycles
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, 0, 4);
    do_read(32'h0000_0010, 0, 1);

    // Error read and out-of-window read
    do_read(32'h0000_0008, 0, 0);
    do_read(32'h0000_0400, 0, 2);
    do_write(32'h0000_0800, 32'h1234_5678, 4'hF, 0, 1, 0);
    do_write(32'h0000_0008, 32'hCAFE_F00D, 4'hF, 1, 1, 0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      if (n == 0) w = 8'($urandom);
      else w = 8'($urandom_range(0, 7));
      a = {22'h0, w, 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset during the write response phase
    pw0 = pw_cnt;
    awaddr = 32'h0000_0014; wdata = 32'hA5A5_5A5A; wstrb = 4'h3;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(8'd5, 32'hA5A5_5A5A, 4'h3);
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("mr_bvalid_before", bvalid, 1);
    rst = 1'b1;
    #1;
    check("mr_bvalid_drop", bvalid, 0);
    check("mr_ready_low", {awready, wready, arready}, 3'b000);
    tick();
    tick();
    rst = 1'b0;
    last_was_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mr_no_response", {bvalid, rvalid}, 2'b00);
    end
    check("mr_no_restrobe", pw_cnt - pw0, 1);
    check("mr_ready_back", {awready, wready, arready}, 3'b111);
    do_read(32'h0000_0014, 0, 0);
    contend(8'd6, $urandom, 8'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
